// File: rtl/relu2_layer_ctrl.sv
// Streams N elements from the layer-2 output buffer through ReLU into relu2 memory.
// Optional negative-element counter enabled by defining RELU2_CTRL_NEGCNT_EN.
module relu2_layer_ctrl #(
   parameter int N        = 64,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 16,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] src_read_addr,
   input  logic [DATA_W-1:0] src_data_out,
   output logic [ADDR_W-1:0] dst_write_addr,
   output logic [DATA_W-1:0] dst_data_in,
   output logic              dst_write_en,
   output logic [ADDR_W-1:0] neg_count
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   localparam logic [ADDR_W-1:0] SRC_BASE_A = ADDR_W'(SRC_BASE);
   localparam logic [ADDR_W-1:0] DST_BASE_A = ADDR_W'(DST_BASE);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N - 1);
   localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

   state_t              state;
   logic [ADDR_W-1:0]   rd_cnt;
   logic [DATA_W-1:0]   relu_val;

   assign relu_val = src_data_out[DATA_W-1] ? '0 : src_data_out;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         rd_cnt         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         src_read_addr  <= '0;
         dst_write_addr <= '0;
         dst_data_in    <= '0;
         dst_write_en   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               dst_write_en <= 1'b0;
               if (start) begin
                  state         <= RUN;
                  busy          <= 1'b1;
                  rd_cnt        <= '0;
                  src_read_addr <= SRC_BASE_A;
               end
            end
            RUN: begin
               // The write-port registers double as the single pipeline stage.
               dst_data_in    <= relu_val;
               dst_write_addr <= DST_BASE_A + rd_cnt;
               dst_write_en   <= 1'b1;
               if (rd_cnt == LAST_IDX) begin
                  state <= FLUSH;
               end else begin
                  rd_cnt        <= rd_cnt + ONE;
                  src_read_addr <= SRC_BASE_A + rd_cnt + ONE;
               end
            end
            FLUSH: begin
               dst_write_en <= 1'b0;
               busy         <= 1'b0;
               done         <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RELU2_CTRL_NEGCNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_count <= '0;
      end else if (state == IDLE && start) begin
         neg_count <= '0;
      end else if (state == RUN && src_data_out[DATA_W-1]) begin
         neg_count <= neg_count + ONE;
      end
   end
`else
   assign neg_count = '0;
`endif

endmodule

// File: tb/tb_relu2_layer_ctrl.sv
// Directed self-checking bench for relu2_layer_ctrl (N=64 instance plus an N=1 edge-case instance).
module tb_relu2_layer_ctrl;

`ifdef RELU2_CTRL_NEGCNT_EN
   localparam int NEG_ON = 1;
`else
   localparam int NEG_ON = 0;
`endif
   localparam logic [31:0] SENT = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start2;
   logic        busy, done, dst_write_en;
   logic [15:0] src_read_addr, dst_write_addr, neg_count;
   logic [31:0] src_data_out, dst_data_in;
   logic        busy2, done2, dst_write_en2;
   logic [15:0] src_read_addr2, dst_write_addr2, neg_count2;
   logic [31:0] src_data_out2, dst_data_in2;

   logic [31:0] src_mem [64];
   logic [31:0] dst_mem [64];
   int          wr_cnt2;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   relu2_layer_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .src_read_addr(src_read_addr), .src_data_out(src_data_out),
      .dst_write_addr(dst_write_addr), .dst_data_in(dst_data_in),
      .dst_write_en(dst_write_en), .neg_count(neg_count)
   );

   relu2_layer_ctrl #(.N(1), .SRC_BASE(5), .DST_BASE(16'hFFFF)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
      .src_read_addr(src_read_addr2), .src_data_out(src_data_out2),
      .dst_write_addr(dst_write_addr2), .dst_data_in(dst_data_in2),
      .dst_write_en(dst_write_en2), .neg_count(neg_count2)
   );

   assign src_data_out  = src_mem[int'(src_read_addr) % 64];
   assign src_data_out2 = (src_read_addr2 == 16'd5) ? 32'd77 : 32'h0000_1234;

   always @(posedge clk) begin
      if (dst_write_en) dst_mem[int'(dst_write_addr) % 64] <= dst_data_in;
      if (dst_write_en2) wr_cnt2 <= wr_cnt2 + 1;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " busy"},  64'(busy), 64'd0);
      check({tag, " done"},  64'(done), 64'd0);
      check({tag, " wen"},   64'(dst_write_en), 64'd0);
      check({tag, " raddr"}, 64'(src_read_addr), 64'd0);
      check({tag, " waddr"}, 64'(dst_write_addr), 64'd0);
      check({tag, " wdata"}, 64'(dst_data_in), 64'd0);
      check({tag, " negcnt"}, 64'(neg_count), 64'd0);
   endtask

   // Leaves the bench 1 time unit after edge 0 (the accepting edge).
   task automatic start_pulse();
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int cyc = 0;
      while (!done && cyc < 300) begin
         @(posedge clk);
         #1 cyc++;
      end
      check({tag, " done_timeout"}, 64'(cyc < 300), 64'd1);
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 64; i++) begin
         src_mem[i] = 32'(i - 32);
         dst_mem[i] = SENT;
      end
   endtask

   initial begin
      int busy_cyc, done_cnt, done_edge, busy_low, done_e1, done_e2;
      start  = 1'b0;
      start2 = 1'b0;
      wr_cnt2 = 0;
      rst    = 1'b1;
      fill_ramp();
      #1 check_outputs_zero("por");
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);

      // Ramp run: timing, addresses and data.
      start_pulse();
      check("t2 busy_edge0", 64'(busy), 64'd1);
      check("t2 raddr_edge0", 64'(src_read_addr), 64'd0);
      busy_cyc = 1; done_cnt = 0; done_edge = 0;
      for (int e = 1; e <= 70; e++) begin
         @(posedge clk);
         #1;
         if (busy) busy_cyc++;
         if (done) begin done_cnt++; done_edge = e; end
         if (e == 1) begin
            check("t2 wen_e1", 64'(dst_write_en), 64'd1);
            check("t2 waddr_e1", 64'(dst_write_addr), 64'd0);
            check("t2 wdata_e1", 64'(dst_data_in), 64'd0);
            check("t2 raddr_e1", 64'(src_read_addr), 64'd1);
         end
         if (e == 40) begin
            check("t2 waddr_e40", 64'(dst_write_addr), 64'd39);
            check("t2 wdata_e40", 64'(dst_data_in), 64'd7);
         end
         if (e == 64) check("t2 wen_flush", 64'(dst_write_en), 64'd1);
         if (e == 65) check("t2 wen_after", 64'(dst_write_en), 64'd0);
      end
      check("t2 busy_cycles", 64'(busy_cyc), 64'd65);
      check("t2 done_count", 64'(done_cnt), 64'd1);
      check("t2 done_edge", 64'(done_edge), 64'd65);
      for (int i = 0; i < 64; i++)
         check($sformatf("t2 dst[%0d]", i), 64'(dst_mem[i]), 64'((i < 32) ? 0 : i - 32));
      check("t2 neg_count", 64'(neg_count), 64'(NEG_ON * 32));

      // Boundary values around the sign bit.
      src_mem[0] = 32'h8000_0000;
      src_mem[1] = 32'h7FFF_FFFF;
      src_mem[2] = 32'h0000_0000;
      src_mem[3] = 32'hFFFF_FFFF;
      for (int i = 4; i < 64; i++) src_mem[i] = 32'(i);
      start_pulse();
      wait_done("t3");
      #20;
      check("t3 dst0", 64'(dst_mem[0]), 64'h0);
      check("t3 dst1", 64'(dst_mem[1]), 64'h7FFF_FFFF);
      check("t3 dst2", 64'(dst_mem[2]), 64'h0);
      check("t3 dst3", 64'(dst_mem[3]), 64'h0);
      check("t3 dst63", 64'(dst_mem[63]), 64'd63);
      check("t3 neg_count", 64'(neg_count), 64'(NEG_ON * 2));

      // start held high: back-to-back runs with only the done cycle between them.
      @(negedge clk) start = 1'b1;
      done_cnt = 0; busy_low = 0; done_e1 = 0; done_e2 = 0;
      for (int e = 0; e <= 135; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) done_e1 = e; else done_e2 = e;
         end
         if (!busy && e < 131) busy_low++;
         if (e == 66) begin
            check("t4 rebusy", 64'(busy), 64'd1);
            start = 1'b0;
         end
      end
      check("t4 done_count", 64'(done_cnt), 64'd2);
      check("t4 done_edge1", 64'(done_e1), 64'd65);
      check("t4 done_edge2", 64'(done_e2), 64'd131);
      check("t4 idle_gap", 64'(busy_low), 64'd1);

      // start pulsed mid-run is ignored.
      start_pulse();
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      done_cnt = 0;
      for (int e = 0; e < 150; e++) begin
         @(posedge clk);
         #1 if (done) done_cnt++;
      end
      check("t4 single_done", 64'(done_cnt), 64'd1);

      // Reset right after element 20 is captured.
      fill_ramp();
      start_pulse();
      repeat (21) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_outputs_zero("t5 midrst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t5 dst19", 64'(dst_mem[19]), 64'd0);
      begin
         int untouched = 0;
         for (int i = 20; i < 64; i++) if (dst_mem[i] === SENT) untouched++;
         check("t5 untouched", 64'(untouched), 64'd44);
      end
      start_pulse();
      wait_done("t5 rerun");
      #20;
      check("t5 dst20", 64'(dst_mem[20]), 64'd0);
      check("t5 dst63", 64'(dst_mem[63]), 64'd31);
      check("t5 neg_count", 64'(neg_count), 64'(NEG_ON * 32));

      // N=1 with base offsets and address wrap.
      @(negedge clk) start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      check("t6 raddr", 64'(src_read_addr2), 64'd5);
      check("t6 busy", 64'(busy2), 64'd1);
      @(posedge clk);
      #1;
      check("t6 wen", 64'(dst_write_en2), 64'd1);
      check("t6 waddr", 64'(dst_write_addr2), 64'hFFFF);
      check("t6 wdata", 64'(dst_data_in2), 64'd77);
      check("t6 done_early", 64'(done2), 64'd0);
      @(posedge clk);
      #1;
      check("t6 done_e2", 64'(done2), 64'd1);
      check("t6 busy_e2", 64'(busy2), 64'd0);
      check("t6 writes", 64'(wr_cnt2), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
